// File: rtl/data_sram_lsu.sv
// data_sram_lsu: MEM-stage load/store controller driving an sram-like data port with in-order
// tracking of in-flight accesses. Optional feature macro: ALIGN_CHECK_EN (adds resp_ale).
module data_sram_lsu #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        resp_valid,
    output logic        resp_wr,
    output logic [31:0] resp_data,
`ifdef ALIGN_CHECK_EN
    output logic        resp_ale,
`endif
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);
    localparam int unsigned IdxW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned OccW = PtrW + 1;

    typedef struct packed {
        logic       wr;
        logic [2:0] op;
        logic [1:0] off;
        logic       cancel;
    } ent_t;

    logic            pend_valid_q, pend_valid_d;
    logic            pend_wr_q, pend_wr_d;
    logic            pend_cancel_q, pend_cancel_d;
    logic [2:0]      pend_op_q, pend_op_d;
    logic [31:0]     pend_addr_q, pend_addr_d;
    logic [31:0]     pend_wdata_q, pend_wdata_d;
    ent_t            q_mem_q [MAX_OUTSTANDING];
    ent_t            q_mem_d [MAX_OUTSTANDING];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [OccW-1:0] occ;
    logic            q_empty, q_full, push, pop, accept, misaligned, rsp_hit;
    ent_t            head;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;
`ifdef ALIGN_CHECK_EN
    logic            ale_q, ale_d;
`endif

    always_comb begin
        count   = wptr_q - rptr_q;
        q_empty = (wptr_q == rptr_q);
        q_full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) && (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
        head    = q_mem_q[rptr_q[IdxW-1:0]];
        push    = pend_valid_q && data_sram_addr_ok;
        pop     = data_sram_data_ok && !q_empty;
        // A slot freed by this cycle's pop can be reused by this cycle's accept.
        occ     = OccW'(count) + OccW'(pend_valid_q) - OccW'(pop);
        misaligned = 1'b0;
`ifdef ALIGN_CHECK_EN
        misaligned = (req_op[1:0] == 2'd1 && req_addr[0]) ||
                     (req_op[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
`endif
        req_ready = !reset && !flush && (!pend_valid_q || data_sram_addr_ok) &&
                    (occ < OccW'(MAX_OUTSTANDING)) &&
                    (!misaligned || (!pend_valid_q && q_empty));
        accept = req_valid && req_ready;
    end

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_wr_d     = pend_wr_q;
        pend_cancel_d = pend_cancel_q;
        pend_op_d     = pend_op_q;
        pend_addr_d   = pend_addr_q;
        pend_wdata_d  = pend_wdata_q;
        if (accept && !misaligned) begin
            pend_valid_d  = 1'b1;
            pend_wr_d     = req_wr;
            pend_cancel_d = 1'b0;
            pend_op_d     = req_op;
            pend_addr_d   = req_addr;
            pend_wdata_d  = req_wdata;
        end else if (push) begin
            pend_valid_d = 1'b0;
        end else if (flush) begin
            pend_cancel_d = 1'b1;
        end

        q_mem_d = q_mem_q;
        if (flush) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) q_mem_d[i].cancel = 1'b1;
        end
        if (push) begin
            q_mem_d[wptr_q[IdxW-1:0]] = '{wr: pend_wr_q, op: pend_op_q, off: pend_addr_q[1:0],
                                          cancel: pend_cancel_q | flush};
        end
        wptr_d = wptr_q + PtrW'(push);
        rptr_d = rptr_q + PtrW'(pop);
`ifdef ALIGN_CHECK_EN
        ale_d = accept && misaligned;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q  <= 1'b0;
            pend_wr_q     <= 1'b0;
            pend_cancel_q <= 1'b0;
            pend_op_q     <= 3'b000;
            pend_addr_q   <= 32'h0;
            pend_wdata_q  <= 32'h0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) q_mem_q[i] <= '0;
`ifdef ALIGN_CHECK_EN
            ale_q         <= 1'b0;
`endif
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_wr_q     <= pend_wr_d;
            pend_cancel_q <= pend_cancel_d;
            pend_op_q     <= pend_op_d;
            pend_addr_q   <= pend_addr_d;
            pend_wdata_q  <= pend_wdata_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            q_mem_q       <= q_mem_d;
`ifdef ALIGN_CHECK_EN
            ale_q         <= ale_d;
`endif
        end
    end

    always_comb begin
        data_sram_req   = pend_valid_q;
        data_sram_wr    = pend_wr_q;
        data_sram_size  = pend_op_q[1:0];
        data_sram_addr  = pend_addr_q;
        data_sram_wstrb = 4'b1111;
        data_sram_wdata = pend_wdata_q;
        case (pend_op_q[1:0])
            2'd0: begin
                data_sram_wstrb = 4'b0001 << pend_addr_q[1:0];
                data_sram_wdata = {4{pend_wdata_q[7:0]}};
            end
            2'd1: begin
                data_sram_wstrb = pend_addr_q[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{pend_wdata_q[15:0]}};
            end
            default: data_sram_wstrb = 4'b1111;
        endcase
        if (!pend_wr_q) data_sram_wstrb = 4'b0000;

        ld_byte = data_sram_rdata[{head.off, 3'b000} +: 8];
        ld_half = data_sram_rdata[{head.off[1], 4'b0000} +: 16];
        case (head.op[1:0])
            2'd0:    ld_data = {{24{ld_byte[7] & ~head.op[2]}}, ld_byte};
            2'd1:    ld_data = {{16{ld_half[15] & ~head.op[2]}}, ld_half};
            default: ld_data = data_sram_rdata;
        endcase

        // Responses popped during a flush belong to the squashed instruction stream.
        rsp_hit    = pop && !head.cancel && !flush;
        resp_valid = rsp_hit;
        resp_wr    = rsp_hit && head.wr;
        resp_data  = (rsp_hit && !head.wr) ? ld_data : 32'h0;
`ifdef ALIGN_CHECK_EN
        resp_valid = rsp_hit || (ale_q && !flush);
        resp_ale   = ale_q && !flush;
`endif
    end

    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (reset)
        !(data_sram_data_ok && q_empty));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && q_full && !pop));

endmodule

// File: tb/tb_data_sram_lsu.sv
// Bench for data_sram_lsu: directed scenarios plus randomized traffic scored against a
// queue model of accepted operations. Honours ALIGN_CHECK_EN when defined.
module tb_data_sram_lsu;
    localparam int unsigned MaxOut = 4;

    logic        clk, reset, req_valid, req_ready, req_wr, flush, resp_valid, resp_wr;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, resp_data;
    logic        data_sram_req, data_sram_wr, addr_ok, data_ok;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata, rdata;
`ifdef ALIGN_CHECK_EN
    logic        resp_ale;
    logic        obs_ale;
`endif

    data_sram_lsu #(.MAX_OUTSTANDING(MaxOut)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_data(resp_data),
`ifdef ALIGN_CHECK_EN
        .resp_ale(resp_ale),
`endif
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(sram_size), .data_sram_wstrb(sram_wstrb),
        .data_sram_addr(sram_addr), .data_sram_wdata(sram_wdata),
        .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cancel;
    } op_t;

    op_t mq[$];          // accepted, unanswered ops; the first n_issued are at the memory
    int  n_issued = 0;
    bit  ale_pending = 1'b0;
    int  n_checks = 0;
    int  n_fail = 0;

    logic        obs_ready, obs_req, obs_resp_valid, obs_resp_wr;
    logic [31:0] obs_resp_data, obs_sram_wdata;
    logic [3:0]  obs_wstrb;
    logic [1:0]  obs_size;
    logic        cap_req;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [1:0]  cap_size;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, required %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(logic [2:0] op, logic [1:0] off, logic [31:0] rd);
        int unsigned u;
        case (op[1:0])
            2'd0: begin
                u = (rd >> (8 * int'(off))) & 32'hFF;
                if (!op[2] && u >= 128) u = u - 256;
            end
            2'd1: begin
                u = (rd >> (16 * int'(off[1]))) & 32'hFFFF;
                if (!op[2] && u >= 32768) u = u - 65536;
            end
            default: u = rd;
        endcase
        return u;
    endfunction

    function automatic logic [3:0] exp_strb(logic wr, logic [2:0] op, logic [1:0] off);
        int unsigned s;
        if (!wr) return 4'h0;
        case (op[1:0])
            2'd0:    s = 1 << off;
            2'd1:    s = 3 << (2 * int'(off[1]));
            default: s = 15;
        endcase
        return s[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(logic [2:0] op, logic [31:0] wd);
        int unsigned w;
        case (op[1:0])
            2'd0:    w = (wd & 32'hFF) * 32'h0101_0101;
            2'd1:    w = (wd & 32'hFFFF) * 32'h0001_0001;
            default: w = wd;
        endcase
        return w;
    endfunction

    task automatic idle();
        req_valid = 1'b0; req_wr = 1'b0; req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    endtask

    // One clock: score outputs mid-cycle against the model, advance the model, cross the edge.
    task automatic tick();
        op_t h, p;
        bit pop, push, exp_rv, exp_ready, unissued, mis;
        @(negedge clk);
        obs_ready = req_ready; obs_req = data_sram_req; obs_resp_valid = resp_valid;
        obs_resp_wr = resp_wr; obs_resp_data = resp_data; obs_wstrb = sram_wstrb;
        obs_sram_wdata = sram_wdata; obs_size = sram_size;
`ifdef ALIGN_CHECK_EN
        obs_ale = resp_ale;
`endif
        pop = data_ok && n_issued > 0;
        unissued = n_issued < mq.size();
        if (pop) begin
            h = mq[0];
            exp_rv = !h.cancel && !flush;
            check_val("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                check_val("resp_wr", 32'(resp_wr), 32'(h.wr));
                check_val("resp_data", resp_data,
                          h.wr ? 32'h0 : exp_load(h.op, h.addr[1:0], rdata));
            end
        end else begin
            exp_rv = ale_pending && !flush;
            check_val("resp_valid_nopop", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv) check_val("ale_data", resp_data, 32'h0);
        end
`ifdef ALIGN_CHECK_EN
        check_val("resp_ale", 32'(resp_ale), 32'(ale_pending && !flush));
`endif
        check_val("sram_req", 32'(data_sram_req), 32'(unissued));
        if (unissued && data_sram_req) begin
            p = mq[n_issued];
            check_val("sram_addr", sram_addr, p.addr);
            check_val("sram_size", 32'(sram_size), 32'(p.op[1:0]));
            check_val("sram_wr", 32'(data_sram_wr), 32'(p.wr));
            check_val("sram_wstrb", 32'(sram_wstrb), 32'(exp_strb(p.wr, p.op, p.addr[1:0])));
            check_val("sram_wdata", sram_wdata, exp_wdata(p.op, p.wdata));
        end
        mis = 1'b0;
`ifdef ALIGN_CHECK_EN
        mis = (req_op[1:0] == 2'd1 && req_addr[0]) ||
              (req_op[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
`endif
        exp_ready = !flush && (!unissued || addr_ok) &&
                    ((mq.size() - int'(pop)) < int'(MaxOut)) && (!mis || mq.size() == 0);
        check_val("req_ready", 32'(req_ready), 32'(exp_ready));

        push = unissued && addr_ok;
        if (pop) void'(mq.pop_front());
        n_issued = n_issued + int'(push) - int'(pop);
        if (flush) foreach (mq[i]) mq[i].cancel = 1'b1;
        ale_pending = 1'b0;
        if (req_valid && exp_ready) begin
            if (mis) ale_pending = 1'b1;
            else mq.push_back('{wr: req_wr, op: req_op, addr: req_addr, wdata: req_wdata,
                                cancel: 1'b0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output int n_resp);
        int guard;
        guard = 0;
        n_resp = 0;
        idle();
        while ((mq.size() > 0 || ale_pending) && guard < 200) begin
            addr_ok = 1'b1;
            data_ok = (n_issued > 0);
            rdata = $urandom;
            tick();
            n_resp += int'(obs_resp_valid);
            guard++;
        end
        idle();
    endtask

    task automatic do_single(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd);
        idle(); req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wd;
        tick();
        idle(); addr_ok = 1'b1;
        tick();
        cap_req = obs_req; cap_wstrb = obs_wstrb; cap_wdata = obs_sram_wdata; cap_size = obs_size;
        idle(); data_ok = 1'b1; rdata = rd;
        tick();
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1);
    end

    initial begin
        int n, acc, reqs;
        reset = 1'b1;
        idle();
        #1;
        check_val("rst_ready", 32'(req_ready), 32'h0);
        check_val("rst_req", 32'(data_sram_req), 32'h0);
        check_val("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_val("rst_wstrb", 32'(sram_wstrb), 32'h0);
        check_val("rst_addr", sram_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        do_single(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234);
        check_val("lb_req_t1", 32'(cap_req), 32'h1);
        check_val("lb_valid", 32'(obs_resp_valid), 32'h1);
        check_val("lb_data", obs_resp_data, 32'hFFFF_FF80);
        do_single(1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF_1234);
        check_val("lbu_data", obs_resp_data, 32'h0000_0080);

        do_single(1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, $urandom);
        check_val("sh_wstrb", 32'(cap_wstrb), 32'hC);
        check_val("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        check_val("sh_size", 32'(cap_size), 32'h1);
        check_val("sh_resp_valid", 32'(obs_resp_valid), 32'h1);
        check_val("sh_resp_wr", 32'(obs_resp_wr), 32'h1);
        check_val("sh_resp_data", obs_resp_data, 32'h0);

        idle(); addr_ok = 1'b1; req_valid = 1'b1; req_op = 3'b010;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            req_addr = 32'h100 + 32'(4 * i);
            tick();
            acc += int'(obs_ready);
        end
        check_val("b2b_accepts", 32'(acc), 32'd4);
        check_val("b2b_full_ready", 32'(obs_ready), 32'h0);
        data_ok = 1'b1; rdata = 32'hA5A5_0001;
        tick();
        check_val("b2b_pop_ready", 32'(obs_ready), 32'h1);
        check_val("b2b_first_data", obs_resp_data, 32'hA5A5_0001);
        drain(n);
        check_val("b2b_resp_count", 32'(n), 32'd4);

        idle(); req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h3000;
        tick();
        idle();
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            reqs += int'(obs_req);
        end
        addr_ok = 1'b1;
        tick();
        reqs += int'(obs_req);
        idle();
        tick();
        reqs += int'(obs_req);
        check_val("stall_req_cycles", 32'(reqs), 32'd4);
        drain(n);

        idle(); addr_ok = 1'b1; req_valid = 1'b1; req_op = 3'b010;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'h10 + 32'(4 * i);
            tick();
        end
        req_valid = 1'b0; flush = 1'b1;
        tick();
        drain(n);
        check_val("flush_silent", 32'(n), 32'd0);
        do_single(1'b0, 3'b010, 32'h4000, 32'h0, 32'h1234_5678);
        check_val("post_flush_lw", obs_resp_data, 32'h1234_5678);

        idle(); req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h600;
        tick();
        idle(); addr_ok = 1'b1;
        tick();
        idle(); req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h604;
        tick();
        idle(); data_ok = 1'b1; rdata = 32'h0BAD_F00D;
        #1;
        check_val("pre_rst_resp", 32'(resp_valid), 32'h1);
        check_val("pre_rst_req", 32'(data_sram_req), 32'h1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_req", 32'(data_sram_req), 32'h0);
        check_val("mid_rst_resp", 32'(resp_valid), 32'h0);
        check_val("mid_rst_ready", 32'(req_ready), 32'h0);
        data_ok = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete(); n_issued = 0; ale_pending = 1'b0;
        tick();
        check_val("post_rst_ready", 32'(obs_ready), 32'h1);
        do_single(1'b0, 3'b001, 32'h0702, 32'h0, 32'h8001_7FFF);
        check_val("post_rst_lh", obs_resp_data, 32'hFFFF_8001);

`ifdef ALIGN_CHECK_EN
        idle(); req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h5002;
        tick();
        idle();
        tick();
        check_val("ale_flag", 32'(obs_ale), 32'h1);
        check_val("ale_valid", 32'(obs_resp_valid), 32'h1);
        check_val("ale_no_req", 32'(obs_req), 32'h0);
`endif

        for (int c = 0; c < 1500; c++) begin
            req_valid = ($urandom_range(9) < 7);
            req_wr = 1'($urandom_range(1));
            req_op = {1'($urandom_range(1)), 2'($urandom_range(2))};
            req_addr = $urandom;
            req_wdata = $urandom;
            flush = ($urandom_range(39) == 0);
            addr_ok = ($urandom_range(9) < 6);
            data_ok = (n_issued > 0) && ($urandom_range(1) == 1);
            rdata = $urandom;
            tick();
        end
        drain(n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
